// File: rtl/demux_stream_router_if.sv
// Stream bundle between the single producer, the N consumers and demux_stream_router.
// The Broadcast_In signal exists only when DEMUX_STREAM_ROUTER_BROADCAST_EN is defined.
interface demux_stream_router_if #(
    parameter int DATA_WIDTH     = 8,
    parameter int NUM_CHANNELS   = 32,
    parameter int SEL_WIDTH      = 5,
    parameter int DROP_CNT_WIDTH = 8
);
    logic                               Enable_In;
    logic                               Valid_In;
    logic                               Ready_Out;
    logic [DATA_WIDTH-1:0]              Data_In;
    logic [SEL_WIDTH-1:0]               Select_In;
    logic [NUM_CHANNELS-1:0]            Valid_Out;
    logic [NUM_CHANNELS-1:0]            Ready_In;
    logic [NUM_CHANNELS*DATA_WIDTH-1:0] Data_Out;
    logic [DROP_CNT_WIDTH-1:0]          Drop_Count_Out;
    logic                               Error_Out;
`ifdef DEMUX_STREAM_ROUTER_BROADCAST_EN
    logic                               Broadcast_In;

    modport master (
        output Enable_In, Valid_In, Data_In, Select_In, Ready_In, Broadcast_In,
        input  Ready_Out, Valid_Out, Data_Out, Drop_Count_Out, Error_Out
    );
    modport slave (
        input  Enable_In, Valid_In, Data_In, Select_In, Ready_In, Broadcast_In,
        output Ready_Out, Valid_Out, Data_Out, Drop_Count_Out, Error_Out
    );
`else
    modport master (
        output Enable_In, Valid_In, Data_In, Select_In, Ready_In,
        input  Ready_Out, Valid_Out, Data_Out, Drop_Count_Out, Error_Out
    );
    modport slave (
        input  Enable_In, Valid_In, Data_In, Select_In, Ready_In,
        output Ready_Out, Valid_Out, Data_Out, Drop_Count_Out, Error_Out
    );
`endif
endinterface

// File: rtl/demux_stream_router.sv
// Registered 1:N stream demux with one-entry per-channel buffers and out-of-range drop accounting.
// Define DEMUX_STREAM_ROUTER_BROADCAST_EN to add the Broadcast_In write-to-all-channels mode.
module demux_stream_router #(
    parameter int DATA_WIDTH     = 8,
    parameter int NUM_CHANNELS   = 32,
    parameter int SEL_WIDTH      = 5,
    parameter int DROP_CNT_WIDTH = 8
) (
    input logic                  Clock_In,
    input logic                  Reset_n_In,
    demux_stream_router_if.slave bus
);
    localparam logic [SEL_WIDTH:0] LP_NUM_CH = (SEL_WIDTH + 1)'(NUM_CHANNELS);

    logic [NUM_CHANNELS-1:0]                 r_full;
    logic [NUM_CHANNELS-1:0][DATA_WIDTH-1:0] r_buf;
    logic [DROP_CNT_WIDTH-1:0]               r_dropCount;
    logic                                    r_error;

    logic [NUM_CHANNELS-1:0] w_selHot;
    logic [NUM_CHANNELS-1:0] w_chanReady;
    logic [NUM_CHANNELS-1:0] w_load;
    logic                    w_inRange;
    logic                    w_broadcast;
    logic                    w_ready;
    logic                    w_accept;
    logic                    w_drop;

    assign w_inRange = ({1'b0, bus.Select_In} < LP_NUM_CH);
`ifdef DEMUX_STREAM_ROUTER_BROADCAST_EN
    assign w_broadcast = bus.Broadcast_In;
`else
    assign w_broadcast = 1'b0;
`endif

    // A channel can take a word if it is empty or is being drained this cycle.
    assign w_chanReady = ~r_full | bus.Ready_In;

    always_comb begin
        w_selHot = '0;
        for (int k = 0; k < NUM_CHANNELS; k++) begin
            w_selHot[k] = (bus.Select_In == SEL_WIDTH'(k));
        end
    end

    always_comb begin
        w_ready = 1'b0;
        if (!Reset_n_In || !bus.Enable_In) begin
            w_ready = 1'b0;
        end else if (w_broadcast) begin
            w_ready = &w_chanReady;
        end else if (w_inRange) begin
            w_ready = |(w_selHot & w_chanReady);
        end else begin
            w_ready = 1'b1;
        end
    end

    assign w_accept = bus.Valid_In && w_ready;
    assign w_drop   = w_accept && !w_broadcast && !w_inRange;
    assign w_load   = w_accept ? (w_broadcast ? {NUM_CHANNELS{1'b1}} : w_selHot)
                               : {NUM_CHANNELS{1'b0}};

    // A load wins over a drain so a draining channel refills without a bubble.
    always_ff @(posedge Clock_In or negedge Reset_n_In) begin
        if (!Reset_n_In) begin
            r_full <= '0;
            r_buf  <= '0;
        end else begin
            for (int k = 0; k < NUM_CHANNELS; k++) begin
                if (w_load[k]) begin
                    r_full[k] <= 1'b1;
                    r_buf[k]  <= bus.Data_In;
                end else if (r_full[k] && bus.Ready_In[k]) begin
                    r_full[k] <= 1'b0;
                end
            end
        end
    end

    always_ff @(posedge Clock_In or negedge Reset_n_In) begin
        if (!Reset_n_In) begin
            r_dropCount <= '0;
            r_error     <= 1'b0;
        end else if (w_drop) begin
            r_error <= 1'b1;
            if (r_dropCount != {DROP_CNT_WIDTH{1'b1}}) begin
                r_dropCount <= r_dropCount + 1'b1;
            end
        end
    end

    assign bus.Ready_Out      = w_ready;
    assign bus.Valid_Out      = r_full;
    assign bus.Data_Out       = r_buf;
    assign bus.Drop_Count_Out = r_dropCount;
    assign bus.Error_Out      = r_error;
endmodule

// File: tb/tb_demux_stream_router.sv
// Randomized self-checking bench for demux_stream_router (20 channels) against a behavioural model.
// Define DEMUX_STREAM_ROUTER_BROADCAST_EN to also exercise the broadcast mode.
module tb_demux_stream_router;
    localparam int DW = 8;
    localparam int NC = 20;
    localparam int SW = 5;
    localparam int CW = 8;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    int   checks   = 0;
    int   failures = 0;

    bit            modelFull[NC];
    logic [DW-1:0] modelBuf[NC];
    int            modelDrops;
    bit            modelError;

    demux_stream_router_if #(.DATA_WIDTH(DW), .NUM_CHANNELS(NC), .SEL_WIDTH(SW), .DROP_CNT_WIDTH(CW)) bus ();

    demux_stream_router #(.DATA_WIDTH(DW), .NUM_CHANNELS(NC), .SEL_WIDTH(SW), .DROP_CNT_WIDTH(CW)) dut (
        .Clock_In   (clk),
        .Reset_n_In (rst_n),
        .bus        (bus)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: got timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    function automatic void modelReset();
        for (int k = 0; k < NC; k++) begin
            modelFull[k] = 1'b0;
            modelBuf[k]  = '0;
        end
        modelDrops = 0;
        modelError = 1'b0;
    endfunction

    function automatic bit expReady();
        int s;
        if (!rst_n || !bus.Enable_In) return 1'b0;
`ifdef DEMUX_STREAM_ROUTER_BROADCAST_EN
        if (bus.Broadcast_In) begin
            for (int k = 0; k < NC; k++) begin
                if (modelFull[k] && !bus.Ready_In[k]) return 1'b0;
            end
            return 1'b1;
        end
`endif
        s = int'(bus.Select_In);
        if (s >= NC) return 1'b1;
        return !modelFull[s] || bus.Ready_In[s];
    endfunction

    function automatic logic [NC-1:0] expValid();
        logic [NC-1:0] v;
        for (int k = 0; k < NC; k++) v[k] = modelFull[k];
        return v;
    endfunction

    function automatic logic [NC*DW-1:0] expData();
        logic [NC*DW-1:0] d;
        for (int k = 0; k < NC; k++) d[k*DW +: DW] = modelBuf[k];
        return d;
    endfunction

    function automatic logic [CW-1:0] expDrops();
        return (modelDrops > 255) ? CW'(255) : CW'(modelDrops);
    endfunction

    task automatic drive(input bit en, input bit v, input logic [DW-1:0] d,
                         input logic [SW-1:0] sel, input logic [NC-1:0] rdy);
        @(negedge clk);
        bus.Enable_In = en;
        bus.Valid_In  = v;
        bus.Data_In   = d;
        bus.Select_In = sel;
        bus.Ready_In  = rdy;
        #1;
    endtask

    // Clock one edge and apply the stream rules to the model using the inputs held across it.
    task automatic advance();
        bit            acc;
        int            s;
        logic [NC-1:0] rdy;
        logic [DW-1:0] d;
        bit            bc;
        acc = bus.Valid_In && expReady();
        s   = int'(bus.Select_In);
        rdy = bus.Ready_In;
        d   = bus.Data_In;
        bc  = 1'b0;
`ifdef DEMUX_STREAM_ROUTER_BROADCAST_EN
        bc = bus.Broadcast_In;
`endif
        @(posedge clk);
        for (int k = 0; k < NC; k++) begin
            if (modelFull[k] && rdy[k]) modelFull[k] = 1'b0;
        end
        if (acc) begin
            if (bc) begin
                for (int k = 0; k < NC; k++) begin
                    modelFull[k] = 1'b1;
                    modelBuf[k]  = d;
                end
            end else if (s < NC) begin
                modelFull[s] = 1'b1;
                modelBuf[s]  = d;
            end else begin
                modelDrops++;
                modelError = 1'b1;
            end
        end
        #1;
    endtask

    task automatic pulseReset();
        @(negedge clk);
        rst_n = 1'b0;
        modelReset();
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic drainAll();
        drive(1'b1, 1'b0, '0, '0, '1);
        advance();
    endtask

    task automatic test_reset();
        bus.Enable_In = 1'b1;
        bus.Valid_In  = 1'b1;
        bus.Data_In   = 8'hFF;
        bus.Select_In = 5'd7;
        bus.Ready_In  = '0;
`ifdef DEMUX_STREAM_ROUTER_BROADCAST_EN
        bus.Broadcast_In = 1'b0;
`endif
        modelReset();
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if (bus.Valid_Out !== '0) begin
            failures++;
            $display("[TB] FAIL reset_valid: got %h expected 0", bus.Valid_Out);
        end
        checks++;
        if (bus.Data_Out !== '0) begin
            failures++;
            $display("[TB] FAIL reset_data: got %h expected 0", bus.Data_Out);
        end
        checks++;
        if (bus.Drop_Count_Out !== '0 || bus.Error_Out !== 1'b0) begin
            failures++;
            $display("[TB] FAIL reset_drop_err: got %0d/%b expected 0/0", bus.Drop_Count_Out, bus.Error_Out);
        end
        checks++;
        if (bus.Ready_Out !== 1'b0) begin
            failures++;
            $display("[TB] FAIL reset_ready: got %b expected 0", bus.Ready_Out);
        end
        @(negedge clk);
        bus.Valid_In = 1'b0;
        rst_n = 1'b1;
    endtask

    task automatic test_basic();
        drive(1'b1, 1'b1, 8'hA5, 5'd7, '0);
        checks++;
        if (bus.Ready_Out !== 1'b1) begin
            failures++;
            $display("[TB] FAIL basic_ready_first: got %b expected 1", bus.Ready_Out);
        end
        advance();
        checks++;
        if (bus.Valid_Out !== (NC'(1) << 7)) begin
            failures++;
            $display("[TB] FAIL basic_valid: got %h expected %h", bus.Valid_Out, NC'(1) << 7);
        end
        checks++;
        if (bus.Data_Out[7*DW +: DW] !== 8'hA5) begin
            failures++;
            $display("[TB] FAIL basic_data: got %h expected a5", bus.Data_Out[7*DW +: DW]);
        end
        drive(1'b1, 1'b1, 8'h11, 5'd7, '0);
        checks++;
        if (bus.Ready_Out !== 1'b0) begin
            failures++;
            $display("[TB] FAIL basic_ready_ch7_full: got %b expected 0", bus.Ready_Out);
        end
        bus.Select_In = 5'd8;
        #1;
        checks++;
        if (bus.Ready_Out !== 1'b1) begin
            failures++;
            $display("[TB] FAIL basic_ready_ch8: got %b expected 1", bus.Ready_Out);
        end
        bus.Valid_In = 1'b0;
        advance();
        drainAll();
    endtask

    task automatic test_back_to_back();
        logic [DW-1:0] d;
        int            accepts;
        drive(1'b1, 1'b1, 8'h11, 5'd3, '0);
        advance();
        drive(1'b1, 1'b1, 8'h3C, 5'd3, NC'(1) << 3);
        checks++;
        if (bus.Ready_Out !== 1'b1) begin
            failures++;
            $display("[TB] FAIL b2b_ready: got %b expected 1", bus.Ready_Out);
        end
        advance();
        checks++;
        if (bus.Valid_Out[3] !== 1'b1 || bus.Data_Out[3*DW +: DW] !== 8'h3C) begin
            failures++;
            $display("[TB] FAIL b2b_replace: got %b/%h expected 1/3c", bus.Valid_Out[3], bus.Data_Out[3*DW +: DW]);
        end
        accepts = 0;
        for (int i = 0; i < 10; i++) begin
            d = DW'($urandom);
            drive(1'b1, 1'b1, d, 5'd3, NC'(1) << 3);
            if (bus.Ready_Out === 1'b1) accepts++;
            advance();
            checks++;
            if (bus.Data_Out[3*DW +: DW] !== d || bus.Valid_Out[3] !== 1'b1) begin
                failures++;
                $display("[TB] FAIL b2b_word%0d: got %b/%h expected 1/%h", i, bus.Valid_Out[3], bus.Data_Out[3*DW +: DW], d);
            end
        end
        checks++;
        if (accepts != 10) begin
            failures++;
            $display("[TB] FAIL b2b_accepts: got %0d expected 10", accepts);
        end
        drainAll();
    endtask

    task automatic test_enable();
        drive(1'b1, 1'b1, 8'h55, 5'd5, '0);
        advance();
        drive(1'b0, 1'b1, 8'h66, 5'd5, NC'(1) << 5);
        checks++;
        if (bus.Ready_Out !== 1'b0) begin
            failures++;
            $display("[TB] FAIL enable_ready: got %b expected 0", bus.Ready_Out);
        end
        advance();
        checks++;
        if (bus.Valid_Out[5] !== 1'b0) begin
            failures++;
            $display("[TB] FAIL enable_drain: got %b expected 0", bus.Valid_Out[5]);
        end
        drive(1'b0, 1'b1, 8'h77, 5'd9, '0);
        advance();
        checks++;
        if (bus.Valid_Out !== '0) begin
            failures++;
            $display("[TB] FAIL enable_no_accept: got %h expected 0", bus.Valid_Out);
        end
    endtask

    task automatic test_random();
        pulseReset();
        for (int i = 0; i < 500; i++) begin
            drive($urandom_range(0, 9) != 0, $urandom_range(0, 3) != 0, DW'($urandom),
                  SW'($urandom_range(0, 31)), NC'($urandom));
            checks++;
            if (bus.Ready_Out !== expReady()) begin
                failures++;
                $display("[TB] FAIL rand_ready@%0d: got %b expected %b", i, bus.Ready_Out, expReady());
            end
            advance();
            checks++;
            if (bus.Valid_Out !== expValid() || bus.Data_Out !== expData()) begin
                failures++;
                $display("[TB] FAIL rand_chan@%0d: got %h/%h expected %h/%h", i, bus.Valid_Out, bus.Data_Out, expValid(), expData());
            end
            checks++;
            if (bus.Drop_Count_Out !== expDrops() || bus.Error_Out !== modelError) begin
                failures++;
                $display("[TB] FAIL rand_drop@%0d: got %0d/%b expected %0d/%b", i, bus.Drop_Count_Out, bus.Error_Out, expDrops(), modelError);
            end
        end
        drainAll();
    endtask

    task automatic test_drop_saturate();
        pulseReset();
        for (int i = 0; i < 300; i++) begin
            drive(1'b1, 1'b1, DW'($urandom), 5'd25, '1);
            checks++;
            if (bus.Ready_Out !== 1'b1) begin
                failures++;
                $display("[TB] FAIL drop_ready@%0d: got %b expected 1", i, bus.Ready_Out);
            end
            advance();
            if (i == 0) begin
                checks++;
                if (bus.Error_Out !== 1'b1 || bus.Drop_Count_Out !== 8'd1) begin
                    failures++;
                    $display("[TB] FAIL drop_first: got %b/%0d expected 1/1", bus.Error_Out, bus.Drop_Count_Out);
                end
            end
        end
        checks++;
        if (bus.Drop_Count_Out !== 8'd255 || bus.Error_Out !== 1'b1) begin
            failures++;
            $display("[TB] FAIL drop_saturate: got %0d/%b expected 255/1", bus.Drop_Count_Out, bus.Error_Out);
        end
        checks++;
        if (bus.Valid_Out !== '0) begin
            failures++;
            $display("[TB] FAIL drop_no_valid: got %h expected 0", bus.Valid_Out);
        end
    endtask

    task automatic test_async_reset();
        drive(1'b1, 1'b1, 8'h01, 5'd1, '0);
        advance();
        drive(1'b1, 1'b1, 8'h02, 5'd2, '0);
        advance();
        drive(1'b1, 1'b1, 8'h0A, 5'd10, '0);
        advance();
        drive(1'b1, 1'b1, 8'h13, 5'd19, '0);
        advance();
        checks++;
        if (bus.Valid_Out !== expValid()) begin
            failures++;
            $display("[TB] FAIL areset_pre: got %h expected %h", bus.Valid_Out, expValid());
        end
        @(negedge clk);
        bus.Valid_In = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if (bus.Valid_Out !== '0 || bus.Drop_Count_Out !== '0 || bus.Error_Out !== 1'b0) begin
            failures++;
            $display("[TB] FAIL areset_now: got %h/%0d/%b expected 0/0/0", bus.Valid_Out, bus.Drop_Count_Out, bus.Error_Out);
        end
        modelReset();
        @(negedge clk);
        rst_n = 1'b1;
    endtask

`ifdef DEMUX_STREAM_ROUTER_BROADCAST_EN
    task automatic test_broadcast();
        drive(1'b1, 1'b1, 8'h11, 5'd0, '0);
        advance();
        drive(1'b1, 1'b1, 8'h5A, 5'd25, '0);
        bus.Broadcast_In = 1'b1;
        #1;
        checks++;
        if (bus.Ready_Out !== 1'b0) begin
            failures++;
            $display("[TB] FAIL bcast_blocked: got %b expected 0", bus.Ready_Out);
        end
        advance();
        bus.Ready_In = NC'(1);
        #1;
        checks++;
        if (bus.Ready_Out !== 1'b1) begin
            failures++;
            $display("[TB] FAIL bcast_ready: got %b expected 1", bus.Ready_Out);
        end
        advance();
        checks++;
        if (bus.Valid_Out !== '1 || bus.Data_Out !== {NC{8'h5A}} || bus.Drop_Count_Out !== '0) begin
            failures++;
            $display("[TB] FAIL bcast_all: got %h/%h/%0d expected all ones/5a/0", bus.Valid_Out, bus.Data_Out, bus.Drop_Count_Out);
        end
        bus.Broadcast_In = 1'b0;
        drainAll();
    endtask
`endif

    initial begin
        test_reset();
        test_basic();
        test_back_to_back();
        test_enable();
        test_random();
        test_drop_saturate();
        test_async_reset();
`ifdef DEMUX_STREAM_ROUTER_BROADCAST_EN
        test_broadcast();
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/demux_stream_router.md
Name: demux_stream_router

Overview:
- Parametrised, registered 1:N stream demultiplexer with valid/ready handshake and per-channel one-entry output buffers; the successor to the fixed-width 1:32 demux.
- Routes each accepted input word to the channel given by Select_In.
- Isolates each output channel's back-pressure from the other channels.
- Sits between a single producer and NUM_CHANNELS independent consumers.

Parameters:
- DATA_WIDTH, 8: width of each data word.
- NUM_CHANNELS, 32: number of output channels; legal range 2..2^SEL_WIDTH.
- SEL_WIDTH, 5: width of Select_In.
- DROP_CNT_WIDTH, 8: width of the saturating drop counter.

Ports:
- Clock_In  input  1  single clock; all state updates on the rising edge.
- Reset_n_In  input  1  reset, asynchronous assert, active-low.
- Enable_In  input  1  when 0, no new input is accepted; buffered words still drain.
- Valid_In  input  1  input word valid.
- Ready_Out  output  1  input word acceptable this cycle.
- Data_In  input  DATA_WIDTH  input word.
- Select_In  input  SEL_WIDTH  destination channel index; sampled with Data_In.
- Valid_Out  output  NUM_CHANNELS  bit k: channel k holds a word.
- Ready_In  input  NUM_CHANNELS  bit k: channel k consumer takes the word.
- Data_Out  output  NUM_CHANNELS*DATA_WIDTH  channel k word at bits [k*DATA_WIDTH +: DATA_WIDTH].
- Drop_Count_Out  output  DROP_CNT_WIDTH  count of words dropped for an out-of-range select.
- Error_Out  output  1  sticky flag, set on first drop.

Behaviour:
- Reset (Reset_n_In=0, asynchronous): Valid_Out=0, Data_Out=0, Drop_Count_Out=0, Error_Out=0. Ready_Out is combinational and therefore 0 during reset.
- Per-channel state is full[k] (drives Valid_Out[k]) and buf[k] (drives the Data_Out slice).
- Channel k drains on a cycle where full[k] && Ready_In[k].
- In-range select (Select_In < NUM_CHANNELS): Ready_Out = Enable_In && (!full[s] || Ready_In[s]), where s = Select_In. This is pass-through readiness: a full buffer draining this cycle accepts a new word in the same cycle.
- Out-of-range select (Select_In >= NUM_CHANNELS): Ready_Out = Enable_In.
- Accept = Valid_In && Ready_Out.
- Accept, in range: buf[s] <= Data_In, full[s] <= 1 at the next edge. Latency is 1 cycle from accept to Valid_Out[s]=1.
- Simultaneous drain and accept on the same channel: the new word replaces the old one and full stays 1. No bubble; throughput is 1 word/cycle per channel.
- Drain without accept: full[k] <= 0. buf[k] holds its last value, so Data_Out is don't-care while Valid_Out[k]=0, but the RTL must not clear it.
- Accept, out of range: the word is discarded and Error_Out <= 1 (sticky until reset). Drop_Count_Out increments and saturates at all-ones with no wrap.
- Channels are fully independent: a stalled channel never blocks inputs addressed to other channels.
- Valid_Out[k] is never deasserted until drained (AXI-style stability). Data_Out slice k is stable while Valid_Out[k]=1 && !Ready_In[k].
- Enable_In falling mid-stream: no accepts from that cycle; existing buffers drain normally.
- Reset mid-operation: all buffered words are lost and the counter and flag clear immediately.
- Ready_Out depends combinationally on Select_In, Enable_In, Ready_In and state; it has no combinational dependence on Valid_In.

Optional Feature:
- Macro: DEMUX_STREAM_ROUTER_BROADCAST_EN.
- Defined: adds input port Broadcast_In (1 bit). When Broadcast_In=1, Select_In is ignored and Ready_Out = Enable_In && AND over all k of (!full[k] || Ready_In[k]).
- Broadcast accept writes Data_In to every buf[k] and sets every full[k]. It never counts as a drop.
- Not defined: the port is absent and the behaviour is exactly as above.

Test Plan:
- Reset, then Valid_In=1, Data_In=0xA5, Select_In=7, all Ready_In=0 → next cycle Valid_Out[7]=1, slice 7=0xA5, all other Valid_Out=0. Ready_Out=0 for a second word to channel 7 and =1 for a word to channel 8.
- Channel 3 full, Ready_In[3]=1, new word 0x3C to channel 3 in the same cycle → accepted, Valid_Out[3] stays 1, slice 3=0x3C next cycle. Sustain 10 back-to-back words → 10 accepts in 10 cycles.
- NUM_CHANNELS=20, Select_In=25, Valid_In=1 for 300 cycles → Ready_Out=1 throughout, no Valid_Out set, Error_Out=1 after the first accept, Drop_Count_Out saturates at 255.
- Enable_In=0 with channel 5 full and Ready_In[5]=1 → Ready_Out=0, Valid_Out[5] falls after 1 cycle, no new accepts.
- Assert Reset_n_In=0 asynchronously mid-cycle with 4 channels full → Valid_Out=0, Drop_Count_Out=0 and Error_Out=0 immediately, before the next clock edge.
- With DEMUX_STREAM_ROUTER_BROADCAST_EN, Broadcast_In=1, Data_In=0x5A, channel 0 full and not ready → Ready_Out=0. Release Ready_In[0] → accept, and all channels show 0x5A with Valid_Out all ones.
